fetch_unit: RTL



---
 rtl/fetch_unit_if.sv | 34 +++
 rtl/fetch_unit.sv | 124 ++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch unit bundle: instruction-memory request/grant/response, redirect input,
// and the valid/ready instruction handoff to decode.
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] instruccion;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic        inst_ready;
    logic        misalign_trap;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        input  redirect_valid, redirect_pc,
        output instruccion, pc_out, inst_valid,
        input  inst_ready,
        output misalign_trap
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        output redirect_valid, redirect_pc,
        input  instruccion, pc_out, inst_valid,
        output inst_ready,
        input  misalign_trap
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, in-order imem requests, response FIFO, redirect flush.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect enters a sticky trap.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    localparam int unsigned PW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {BOOT, RUN, TRAP} state_t;

    state_t        state;
    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [31:0]   fifo_inst [FIFO_DEPTH];
    logic [31:0]   fifo_pc   [FIFO_DEPTH];

    logic [31:0]   target;
    logic          misaligned;
    logic [CW:0]   in_use;
    logic          req;
    logic          grant;
    logic          resp;
    logic          push;
    logic          pop;
    logic          valid;

    always_comb begin
        target = bus.redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
        misaligned = (bus.redirect_pc[1:0] != 2'b00);
`else
        target[1:0] = 2'b00;
        misaligned  = 1'b0;
`endif
    end

    // Every request in flight holds a FIFO slot, so a response can never find the FIFO full.
    assign in_use = {1'b0, outstanding} + {1'b0, fifo_count};
    assign req    = (state == RUN) && !bus.redirect_valid && (in_use < (CW+1)'(FIFO_DEPTH));
    assign grant  = req && bus.imem_gnt;
    assign resp   = bus.imem_rvalid && (outstanding != '0);
    assign valid  = (fifo_count != '0);
    assign push   = resp && (discard == '0) && (state == RUN) && !bus.redirect_valid;
    assign pop    = valid && bus.inst_ready && !bus.redirect_valid;

    assign bus.imem_req    = req;
    assign bus.imem_addr   = fetch_pc;
    assign bus.inst_valid  = valid;
    assign bus.instruccion = valid ? fifo_inst[rd_ptr] : NOP;
    assign bus.pc_out      = valid ? fifo_pc[rd_ptr] : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.misalign_trap = (state == TRAP);
`else
    assign bus.misalign_trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            outstanding <= outstanding + CW'(grant) - CW'(resp);
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (bus.redirect_valid) begin
                        // Everything still in flight after this cycle belongs to the old path.
                        discard    <= outstanding - CW'(resp);
                        fifo_count <= '0;
                        wr_ptr     <= '0;
                        rd_ptr     <= '0;
                        if (misaligned) begin
                            state <= TRAP;
                        end else begin
                            fetch_pc <= target;
                            resp_pc  <= target;
                        end
                    end else begin
                        if (grant)
                            fetch_pc <= fetch_pc + 32'd4;
                        if (resp && (discard != '0))
                            discard <= discard - CW'(1);
                        if (push) begin
                            wr_ptr  <= wr_ptr + PW'(1);
                            resp_pc <= resp_pc + 32'd4;
                        end
                        if (pop)
                            rd_ptr <= rd_ptr + PW'(1);
                        fifo_count <= fifo_count + CW'(push) - CW'(pop);
                    end
                end
                TRAP: begin
                    if (resp && (discard != '0))
                        discard <= discard - CW'(1);
                end
                default: state <= BOOT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_inst[wr_ptr] <= bus.imem_rdata;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end
endmodule
